// File: rtl/node_interface.sv
// Network interface between a PE and one switch local port: TX FIFO of flits, RX FIFO of payloads.
// Optional statistics counters are built when NODE_IF_STATS_EN is defined.
module node_interface #(
    parameter int DATA_SIZE = 32,
    parameter int ADDR_SIZE = 4,
    parameter int NODES_NUM = 9,
    parameter int ADDR      = 0,
    parameter int TX_LOG2   = 3,
    parameter int RX_LOG2   = 3
) (
    input  logic                         clk,
    input  logic                         a_rst,
    input  logic                         pe_tx_valid,
    output logic                         pe_tx_ready,
    input  logic [ADDR_SIZE-1:0]         pe_tx_dest,
    input  logic [DATA_SIZE-1:0]         pe_tx_data,
    output logic                         pe_rx_valid,
    input  logic                         pe_rx_ready,
    output logic [DATA_SIZE-1:0]         pe_rx_data,
    output logic [DATA_SIZE+ADDR_SIZE:0] sw_data_o,
    output logic                         sw_wr_ready_out,
    input  logic                         sw_r_ready_in,
    input  logic [DATA_SIZE+ADDR_SIZE:0] sw_data_i,
    input  logic                         sw_wr_ready_in,
    output logic                         sw_r_ready_out,
    output logic                         tx_err,
    output logic                         rx_err,
    output logic [15:0]                  stat_tx,
    output logic [15:0]                  stat_rx,
    output logic [15:0]                  stat_drop
);
    localparam int BUS_SIZE = DATA_SIZE + ADDR_SIZE + 1;
    localparam int TX_DEPTH = 1 << TX_LOG2;
    localparam int RX_DEPTH = 1 << RX_LOG2;
    localparam logic [ADDR_SIZE-1:0] LP_ADDR = ADDR_SIZE'(ADDR);

    logic [BUS_SIZE-1:0]  r_tx_mem [TX_DEPTH];
    logic [TX_LOG2:0]     r_tx_wr, r_tx_rd;
    logic [DATA_SIZE-1:0] r_rx_mem [RX_DEPTH];
    logic [RX_LOG2:0]     r_rx_wr, r_rx_rd;
    logic                 r_tx_err, r_rx_err;

    logic w_tx_full, w_tx_empty, w_rx_full, w_rx_empty;
    logic w_tx_acc, w_tx_bad, w_tx_push, w_tx_pop, w_tx_drop;
    logic w_rx_acc, w_rx_good, w_rx_push, w_rx_pop, w_rx_drop;

    // Full when the wrap bits differ but the index bits match.
    assign w_tx_empty = (r_tx_wr == r_tx_rd);
    assign w_tx_full  = (r_tx_wr[TX_LOG2] != r_tx_rd[TX_LOG2]) &&
                        (r_tx_wr[TX_LOG2-1:0] == r_tx_rd[TX_LOG2-1:0]);
    assign w_rx_empty = (r_rx_wr == r_rx_rd);
    assign w_rx_full  = (r_rx_wr[RX_LOG2] != r_rx_rd[RX_LOG2]) &&
                        (r_rx_wr[RX_LOG2-1:0] == r_rx_rd[RX_LOG2-1:0]);

    assign w_tx_acc  = pe_tx_valid & ~w_tx_full;
    assign w_tx_bad  = (pe_tx_dest == LP_ADDR) ||
                       ({{(32-ADDR_SIZE){1'b0}}, pe_tx_dest} >= 32'(NODES_NUM));
    assign w_tx_push = w_tx_acc & ~w_tx_bad;
    assign w_tx_drop = w_tx_acc & w_tx_bad;
    assign w_tx_pop  = ~w_tx_empty & sw_r_ready_in;

    assign w_rx_acc  = sw_wr_ready_in & ~w_rx_full;
    assign w_rx_good = sw_data_i[BUS_SIZE-1] && (sw_data_i[DATA_SIZE +: ADDR_SIZE] == LP_ADDR);
    assign w_rx_push = w_rx_acc & w_rx_good;
    assign w_rx_drop = w_rx_acc & ~w_rx_good;
    assign w_rx_pop  = ~w_rx_empty & pe_rx_ready;

    assign pe_tx_ready     = ~w_tx_full;
    assign sw_wr_ready_out = ~w_tx_empty;
    assign sw_data_o       = r_tx_mem[r_tx_rd[TX_LOG2-1:0]];
    assign sw_r_ready_out  = ~w_rx_full;
    assign pe_rx_valid     = ~w_rx_empty;
    assign pe_rx_data      = r_rx_mem[r_rx_rd[RX_LOG2-1:0]];
    assign tx_err          = r_tx_err;
    assign rx_err          = r_rx_err;

    // Memories are cleared too so the data outputs read 0 out of reset.
    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_tx_wr  <= '0;
            r_tx_rd  <= '0;
            r_tx_err <= 1'b0;
            for (int i = 0; i < TX_DEPTH; i++) r_tx_mem[i] <= '0;
        end else begin
            if (w_tx_push) begin
                r_tx_mem[r_tx_wr[TX_LOG2-1:0]] <= {1'b1, pe_tx_dest, pe_tx_data};
                r_tx_wr <= r_tx_wr + 1'b1;
            end
            if (w_tx_pop) r_tx_rd <= r_tx_rd + 1'b1;
            r_tx_err <= w_tx_drop;
        end
    end

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_rx_wr  <= '0;
            r_rx_rd  <= '0;
            r_rx_err <= 1'b0;
            for (int i = 0; i < RX_DEPTH; i++) r_rx_mem[i] <= '0;
        end else begin
            if (w_rx_push) begin
                r_rx_mem[r_rx_wr[RX_LOG2-1:0]] <= sw_data_i[DATA_SIZE-1:0];
                r_rx_wr <= r_rx_wr + 1'b1;
            end
            if (w_rx_pop) r_rx_rd <= r_rx_rd + 1'b1;
            r_rx_err <= w_rx_drop;
        end
    end

`ifdef NODE_IF_STATS_EN
    logic [15:0] r_stat_tx, r_stat_rx, r_stat_drop;

    function automatic logic [15:0] sat_add16(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'b0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    always_ff @(posedge clk or negedge a_rst) begin
        if (!a_rst) begin
            r_stat_tx   <= '0;
            r_stat_rx   <= '0;
            r_stat_drop <= '0;
        end else begin
            r_stat_tx   <= sat_add16(r_stat_tx, {1'b0, w_tx_pop});
            r_stat_rx   <= sat_add16(r_stat_rx, {1'b0, w_rx_push});
            r_stat_drop <= sat_add16(r_stat_drop, {1'b0, w_tx_drop} + {1'b0, w_rx_drop});
        end
    end

    assign stat_tx   = r_stat_tx;
    assign stat_rx   = r_stat_rx;
    assign stat_drop = r_stat_drop;
`else
    assign stat_tx   = '0;
    assign stat_rx   = '0;
    assign stat_drop = '0;
`endif

endmodule
